// File: rtl/mesm6_mem_arbiter.sv
// mesm6_mem_arbiter: merges the core's instruction and data buses onto one
// single-port memory. Data cycles go ahead of fetch cycles. The requests are
// sampled once in IDLE. All outputs are registered. Completion is reported to
// the core as one-cycle *_done pulses, issued together in the DONE state.
module mesm6_mem_arbiter #(
   parameter int unsigned AW = 15,
   parameter int unsigned DW = 48
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ibus_fetch,
   input  logic [AW-1:0] ibus_addr,
   output logic [DW-1:0] ibus_input,
   output logic          ibus_done,
   input  logic          dbus_read,
   input  logic          dbus_write,
   input  logic [AW-1:0] dbus_addr,
   input  logic [DW-1:0] dbus_output,
   output logic [DW-1:0] dbus_input,
   output logic          dbus_done,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ack,
   output logic          bus_err
);

   typedef enum logic [1:0] {IDLE, DCYC, ICYC, DONE} state_t;

   state_t        state, state_nx;
   logic          pend_i, pend_i_nx;
   logic          data_served, data_served_nx;
   logic [AW-1:0] fetch_addr, fetch_addr_nx;

   logic          mem_req_nx, mem_we_nx;
   logic [AW-1:0] mem_addr_nx;
   logic [DW-1:0] mem_wdata_nx;
   logic [DW-1:0] ibus_input_nx, dbus_input_nx;
   logic          ibus_done_nx, dbus_done_nx, bus_err_nx;

   // Next-state and next-output logic. The done pulses are raised on the
   // transition into DONE, so that they are visible while the state is DONE.
   always_comb begin
      state_nx       = state;
      pend_i_nx      = pend_i;
      data_served_nx = data_served;
      fetch_addr_nx  = fetch_addr;
      mem_req_nx     = mem_req;
      mem_we_nx      = mem_we;
      mem_addr_nx    = mem_addr;
      mem_wdata_nx   = mem_wdata;
      ibus_input_nx  = ibus_input;
      dbus_input_nx  = dbus_input;
      ibus_done_nx   = 1'b0;
      dbus_done_nx   = 1'b0;
      bus_err_nx     = bus_err;
      unique case (state)
         IDLE: begin
            pend_i_nx      = ibus_fetch;
            data_served_nx = 1'b0;
            fetch_addr_nx  = ibus_addr;
            if (dbus_read && dbus_write) bus_err_nx = 1'b1;
            if (dbus_read || dbus_write) begin
               state_nx     = DCYC;
               mem_req_nx   = 1'b1;
               mem_we_nx    = dbus_write;
               mem_addr_nx  = dbus_addr;
               mem_wdata_nx = dbus_output;
            end else if (ibus_fetch) begin
               state_nx    = ICYC;
               mem_req_nx  = 1'b1;
               mem_we_nx   = 1'b0;
               mem_addr_nx = ibus_addr;
            end
         end
         DCYC: begin
            if (mem_ack) begin
               if (!mem_we) dbus_input_nx = mem_rdata;
               data_served_nx = 1'b1;
               if (pend_i) begin
                  // mem_req stays high; the fetch cycle follows back to back
                  state_nx    = ICYC;
                  mem_we_nx   = 1'b0;
                  mem_addr_nx = fetch_addr;
               end else begin
                  state_nx     = DONE;
                  mem_req_nx   = 1'b0;
                  dbus_done_nx = 1'b1;
               end
            end
         end
         ICYC: begin
            if (mem_ack) begin
               ibus_input_nx = mem_rdata;
               pend_i_nx     = 1'b0;
               state_nx      = DONE;
               mem_req_nx    = 1'b0;
               ibus_done_nx  = 1'b1;
               dbus_done_nx  = data_served;
            end
         end
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State and registered outputs; async active-low reset drops mem_req at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         pend_i      <= 1'b0;
         data_served <= 1'b0;
         fetch_addr  <= '0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         ibus_input  <= '0;
         dbus_input  <= '0;
         ibus_done   <= 1'b0;
         dbus_done   <= 1'b0;
         bus_err     <= 1'b0;
      end else begin
         state       <= state_nx;
         pend_i      <= pend_i_nx;
         data_served <= data_served_nx;
         fetch_addr  <= fetch_addr_nx;
         mem_req     <= mem_req_nx;
         mem_we      <= mem_we_nx;
         mem_addr    <= mem_addr_nx;
         mem_wdata   <= mem_wdata_nx;
         ibus_input  <= ibus_input_nx;
         dbus_input  <= dbus_input_nx;
         ibus_done   <= ibus_done_nx;
         dbus_done   <= dbus_done_nx;
         bus_err     <= bus_err_nx;
      end
   end

endmodule

// File: tb/tb_mesm6_mem_arbiter.sv
// Testbench for mesm6_mem_arbiter: a memory responder with programmable ack
// delay, a transaction-level reference model, and directed plus random stimulus.
module tb_mesm6_mem_arbiter;
   localparam int AW = 15;
   localparam int DW = 48;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          ibus_fetch = 1'b0;
   logic [AW-1:0] ibus_addr = '0;
   logic [DW-1:0] ibus_input;
   logic          ibus_done;
   logic          dbus_read = 1'b0;
   logic          dbus_write = 1'b0;
   logic [AW-1:0] dbus_addr = '0;
   logic [DW-1:0] dbus_output = '0;
   logic [DW-1:0] dbus_input;
   logic          dbus_done;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ack;
   logic          bus_err;

   int checks = 0;
   int errors = 0;

   mesm6_mem_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .reset(reset),
      .ibus_fetch(ibus_fetch), .ibus_addr(ibus_addr), .ibus_input(ibus_input), .ibus_done(ibus_done),
      .dbus_read(dbus_read), .dbus_write(dbus_write), .dbus_addr(dbus_addr),
      .dbus_output(dbus_output), .dbus_input(dbus_input), .dbus_done(dbus_done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- memory environment ----------------
   function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
      if (a == 15'o100) return 48'h123456789ABC;
      return {a, 18'h2A5A5, ~a};
   endfunction

   logic [DW-1:0] mem [0:(1<<AW)-1];
   bit            written [0:(1<<AW)-1];
   int            ack_delay = 0;
   int            wait_cnt = 0;
   logic          force_ack = 1'b0;

   assign mem_ack   = force_ack | (mem_req && (wait_cnt >= ack_delay));
   assign mem_rdata = written[mem_addr] ? mem[mem_addr] : init_word(mem_addr);

   always @(posedge clk) begin
      if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
      else wait_cnt <= 0;
   end

   always @(posedge clk) begin
      if (reset && mem_req && mem_ack && mem_we) begin
         mem[mem_addr]     <= mem_wdata;
         written[mem_addr] <= 1'b1;
      end
   end

   // ---------------- memory-port protocol monitor ----------------
   logic          prev_req = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
   logic [AW-1:0] prev_addr = '0;
   logic [DW-1:0] prev_wdata = '0;
   int            req_cycles = 0;

   always @(negedge clk) begin
      if (mem_req === 1'b1) req_cycles++;
      if (prev_req && !prev_ack && reset) begin
         chk("mem_req_held_until_ack", 64'(mem_req), 64'(1));
         if (mem_req === 1'b1) begin
            chk("mem_addr_stable", 64'(mem_addr), 64'(prev_addr));
            chk("mem_we_stable", 64'(mem_we), 64'(prev_we));
            chk("mem_wdata_stable", 64'(mem_wdata), 64'(prev_wdata));
         end
      end
      prev_req   = (mem_req === 1'b1);
      prev_ack   = (mem_ack === 1'b1);
      prev_we    = mem_we;
      prev_addr  = mem_addr;
      prev_wdata = mem_wdata;
   end

   // ---------------- transaction-level reference model ----------------
   logic [DW-1:0] ref_mem [int];
   logic [DW-1:0] exp_ibus = '0;
   logic [DW-1:0] exp_dbus = '0;
   logic          exp_err = 1'b0;

   function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
      return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a);
   endfunction

   // One IDLE sample: the data access happens before the fetch; both-set is a write.
   task automatic model_txn(input bit f, input bit rd, input bit wr,
                            input logic [AW-1:0] ia, input logic [AW-1:0] da,
                            input logic [DW-1:0] wd);
      if (rd && wr) exp_err = 1'b1;
      if (wr) ref_mem[int'(da)] = wd;
      else if (rd) exp_dbus = ref_rd(da);
      if (f) exp_ibus = ref_rd(ia);
   endtask

   task automatic clear_reqs();
      ibus_fetch = 1'b0;
      dbus_read  = 1'b0;
      dbus_write = 1'b0;
   endtask

   // Drives one request set, waits (bounded) for done and checks timing/handshake.
   task automatic run_txn(input string tag, input bit f, input bit rd, input bit wr,
                          input logic [AW-1:0] ia, input logic [AW-1:0] da,
                          input logic [DW-1:0] wd, input int dly, input bit drop_early);
      int  lat;
      int  ncyc;
      bit  idone, ddone, dreq;
      dreq = rd | wr;
      ncyc = int'(dreq) + int'(f);
      @(negedge clk);
      ack_delay   = dly;
      req_cycles  = 0;
      ibus_fetch  = f;
      ibus_addr   = ia;
      dbus_read   = rd;
      dbus_write  = wr;
      dbus_addr   = da;
      dbus_output = wd;
      lat = 0;
      idone = 1'b0;
      ddone = 1'b0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            chk({tag, "_first_we"}, 64'(mem_we), 64'(dreq ? wr : 1'b0));
            chk({tag, "_first_addr"}, 64'(mem_addr), 64'(dreq ? da : ia));
            if (drop_early) clear_reqs();
         end
         if (ibus_done === 1'b1 || dbus_done === 1'b1) begin
            idone = ibus_done;
            ddone = dbus_done;
         end
      end while (!(idone || ddone) && lat < 300);
      clear_reqs();
      chk({tag, "_latency"}, 64'(lat), 64'(1 + ncyc * (dly + 1)));
      chk({tag, "_ibus_done"}, 64'(idone), 64'(f));
      chk({tag, "_dbus_done"}, 64'(ddone), 64'(dreq));
      chk({tag, "_req_low_at_done"}, 64'(mem_req), 64'(0));
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, 64'({ibus_done, dbus_done}), 64'(0));
      chk({tag, "_req_cycles"}, 64'(req_cycles), 64'(ncyc * (dly + 1)));
      model_txn(f, rd, wr, ia, da, wd);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit            f, rd, wr;
      logic [AW-1:0] ia, da;
      logic [DW-1:0] wd;
      int            dly;
      logic [DW-1:0] exp_ibus, exp_dbus;
      bit            exp_err;
   } vec_t;

   function automatic vec_t mk(input bit f, input bit rd, input bit wr,
                               input logic [AW-1:0] ia, input logic [AW-1:0] da,
                               input logic [DW-1:0] wd, input int dly,
                               input logic [DW-1:0] ei, input logic [DW-1:0] ed, input bit ee);
      vec_t v;
      v.f = f; v.rd = rd; v.wr = wr; v.ia = ia; v.da = da; v.wd = wd; v.dly = dly;
      v.exp_ibus = ei; v.exp_dbus = ed; v.exp_err = ee;
      return v;
   endfunction

   vec_t vt [9];

   initial begin
      // f rd wr  ia      da     wd                dly  exp_ibus          exp_dbus          err
      vt[0] = mk(1, 0, 0, 15'o100, 15'd0, 48'h0,            0, 48'h123456789ABC, 48'h0,            0);
      vt[1] = mk(0, 0, 1, 15'd0,   15'd5, 48'hFFFF00000001, 0, 48'h123456789ABC, 48'h0,            0);
      vt[2] = mk(0, 1, 0, 15'd0,   15'd5, 48'h0,            1, 48'h123456789ABC, 48'hFFFF00000001, 0);
      vt[3] = mk(1, 1, 0, 15'o100, 15'd5, 48'h0,            3, 48'h123456789ABC, 48'hFFFF00000001, 0);
      vt[4] = mk(0, 0, 1, 15'd0,   15'd7, 48'hA5A5A5A5A5A5, 10, 48'h123456789ABC, 48'hFFFF00000001, 0);
      vt[5] = mk(0, 1, 1, 15'd0,   15'd9, 48'h0000DEADBEEF, 0, 48'h123456789ABC, 48'hFFFF00000001, 1);
      vt[6] = mk(0, 1, 0, 15'd0,   15'd9, 48'h0,            2, 48'h123456789ABC, 48'h0000DEADBEEF, 1);
      vt[7] = mk(1, 0, 0, 15'd7,   15'd0, 48'h0,            0, 48'hA5A5A5A5A5A5, 48'h0000DEADBEEF, 1);
      vt[8] = mk(1, 0, 1, 15'd5,   15'd5, 48'h000000000123, 1, 48'h000000000123, 48'h0000DEADBEEF, 1);

      // reset state
      repeat (3) @(negedge clk);
      chk("reset_outputs", 64'({mem_req, mem_we, ibus_done, dbus_done, bus_err}), 64'(0));
      chk("reset_ibus_input", 64'(ibus_input), 64'(0));
      chk("reset_dbus_input", 64'(dbus_input), 64'(0));
      chk("reset_mem_addr_wdata", 64'({mem_addr, mem_wdata} != '0), 64'(0));
      #2 reset = 1'b1;

      foreach (vt[i]) begin
         run_txn($sformatf("vec%0d", i), vt[i].f, vt[i].rd, vt[i].wr, vt[i].ia, vt[i].da,
                 vt[i].wd, vt[i].dly, 1'b0);
         chk($sformatf("vec%0d_ibus_input", i), 64'(ibus_input), 64'(vt[i].exp_ibus));
         chk($sformatf("vec%0d_dbus_input", i), 64'(dbus_input), 64'(vt[i].exp_dbus));
         chk($sformatf("vec%0d_bus_err", i), 64'(bus_err), 64'(vt[i].exp_err));
      end

      // mem_ack while idle is ignored
      @(negedge clk);
      force_ack = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("stray_ack_no_activity", 64'({mem_req, ibus_done, dbus_done}), 64'(0));
      end
      force_ack = 1'b0;
      chk("stray_ack_ibus_input", 64'(ibus_input), 64'(exp_ibus));
      chk("stray_ack_dbus_input", 64'(dbus_input), 64'(exp_dbus));

      // requests dropped right after the sample still complete
      run_txn("drop", 1'b1, 1'b1, 1'b0, 15'd9, 15'd7, 48'h0, 2, 1'b1);
      chk("drop_dbus_input", 64'(dbus_input), 64'(exp_dbus));
      chk("drop_ibus_input", 64'(ibus_input), 64'(exp_ibus));

      // async reset in the middle of a slow data cycle
      @(negedge clk);
      ack_delay = 10;
      dbus_read = 1'b1;
      dbus_addr = 15'd5;
      repeat (3) @(negedge clk);
      chk("rst_mem_req_before", 64'(mem_req), 64'(1));
      #2 reset = 1'b0;
      #1;
      chk("rst_async_ctrl", 64'({mem_req, mem_we, ibus_done, dbus_done, bus_err}), 64'(0));
      chk("rst_async_data", 64'({ibus_input != '0, dbus_input != '0, mem_addr != '0, mem_wdata != '0}), 64'(0));
      clear_reqs();
      exp_ibus = '0;
      exp_dbus = '0;
      exp_err  = 1'b0;
      @(negedge clk);
      #2 reset = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("post_reset_quiet", 64'({mem_req, ibus_done, dbus_done, bus_err}), 64'(0));
      end

      // randomized transactions against the reference model
      for (int n = 0; n < 40; n++) begin
         bit            f, rd, wr, drop;
         int            r, dly;
         logic [AW-1:0] ia, da;
         logic [63:0]   tmp;
         r  = $urandom_range(0, 9);
         rd = (r <= 3) || (r == 8);
         wr = (r >= 4 && r <= 8);
         f  = ($urandom_range(0, 1) == 1) || !(rd || wr);
         ia = AW'($urandom_range(0, 15));
         da = AW'($urandom_range(0, 15));
         tmp = {$urandom, $urandom};
         dly = $urandom_range(0, 3);
         drop = ($urandom_range(0, 4) == 0);
         run_txn($sformatf("rnd%0d", n), f, rd, wr, ia, da, tmp[DW-1:0], dly, drop);
         chk($sformatf("rnd%0d_ibus_input", n), 64'(ibus_input), 64'(exp_ibus));
         chk($sformatf("rnd%0d_dbus_input", n), 64'(dbus_input), 64'(exp_dbus));
         chk($sformatf("rnd%0d_bus_err", n), 64'(bus_err), 64'(exp_err));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

endmodule
